// File: rtl/gpi_input_conditioner.sv
// Pad-to-GPI input conditioner: per-bit 2-flop synchronizer followed by a
// counter-based debouncer that also produces registered rise/fall pulses.
module gpi_input_conditioner #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             bypass,
  output logic [WIDTH-1:0] gpi_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] W_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] W_LOW  = 2'd3;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Only sync2_q is consumed downstream; sync1_q may go metastable.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             rise_q, rise_d;
      logic             fall_q, fall_d;
      logic             lvl;

      assign lvl = sync2_q[gi];

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (bypass) begin
          // Output follows the synchronized level; the FSM is parked in the
          // matching stable state so debouncing resumes cleanly afterwards.
          level_d = lvl;
          state_d = lvl ? S_HIGH : S_LOW;
          cnt_d   = '0;
          rise_d  = lvl & ~level_q;
          fall_d  = ~lvl & level_q;
        end else begin
          case (state_q)
            S_LOW: begin
              if (lvl) begin
                state_d = W_HIGH;
                cnt_d   = '0;
              end
            end
            W_HIGH: begin
              if (!lvl) begin
                state_d = S_LOW;
                cnt_d   = '0;
              end else if (cnt_q == CNT_LAST) begin
                state_d = S_HIGH;
                level_d = 1'b1;
                rise_d  = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            S_HIGH: begin
              if (!lvl) begin
                state_d = W_LOW;
                cnt_d   = '0;
              end
            end
            W_LOW: begin
              if (lvl) begin
                state_d = S_HIGH;
                cnt_d   = '0;
              end else if (cnt_q == CNT_LAST) begin
                state_d = S_LOW;
                level_d = 1'b0;
                fall_d  = 1'b1;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            default: begin
              state_d = S_LOW;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          level_q <= level_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
        end
      end

      assign gpi_out[gi]    = level_q;
      assign rise_pulse[gi] = rise_q;
      assign fall_pulse[gi] = fall_q;
    end
  endgenerate

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// Directed bench for gpi_input_conditioner with STABLE_CYCLES=4 (commit at
// capture edge + 6, bypass output at capture edge + 2).
module tb_gpi_input_conditioner;

  localparam int W = 4;

  logic         PCLK = 1'b0;
  logic         PRESET = 1'b1;
  logic [W-1:0] pad_in = '0;
  logic         bypass = 1'b0;
  logic [W-1:0] gpi_out, rise_pulse, fall_pulse;

  int checks = 0;
  int errors = 0;

  gpi_input_conditioner #(.WIDTH(W), .STABLE_CYCLES(4)) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .pad_in     (pad_in),
    .bypass     (bypass),
    .gpi_out    (gpi_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 PCLK = ~PCLK;

  // Returns 1 ns after the next rising edge; inputs set here are captured
  // into the first sync stage at the following edge.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    pad_in = 4'hF;
    PRESET = 1'b1;
    repeat (3) tick();
    checks++;
    if (gpi_out !== 4'h0 || rise_pulse !== 4'h0 || fall_pulse !== 4'h0) begin
      errors++;
      $display("FAIL reset_hold gpi=%h rise=%h fall=%h expected all 0", gpi_out, rise_pulse, fall_pulse);
    end
    PRESET = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (gpi_out !== ((e >= 6) ? 4'hF : 4'h0) || rise_pulse !== ((e == 6) ? 4'hF : 4'h0)
          || fall_pulse !== 4'h0) begin
        errors++;
        $display("FAIL reset_release edge %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("reset release: gpi=%h after commit", gpi_out);
    pad_in = 4'h0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (gpi_out !== ((e >= 6) ? 4'h0 : 4'hF) || fall_pulse !== ((e == 6) ? 4'hF : 4'h0)
          || rise_pulse !== 4'h0) begin
        errors++;
        $display("FAIL all_fall edge %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("all fall: gpi=%h", gpi_out);
  endtask

  task automatic test_clean_edge();
    pad_in = 4'b0010;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (gpi_out !== ((e >= 6) ? 4'b0010 : 4'b0000) || rise_pulse !== ((e == 6) ? 4'b0010 : 4'b0000)
          || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL clean_edge edge %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("clean edge bit1: gpi=%h", gpi_out);
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 4; t++) begin
      pad_in[2] = (t % 2 == 0);
      repeat (2) begin
        tick();
        checks++;
        if (rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000 || gpi_out !== 4'b0010) begin
          errors++;
          $display("FAIL bounce_phase %0d gpi=%h rise=%h fall=%h", t, gpi_out, rise_pulse, fall_pulse);
        end
      end
    end
    pad_in[2] = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (gpi_out !== ((e >= 6) ? 4'b0110 : 4'b0010) || rise_pulse !== ((e == 6) ? 4'b0100 : 4'b0000)
          || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_settle edge %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("bounce bit2: gpi=%h", gpi_out);
  endtask

  task automatic test_short_glitch();
    pad_in[0] = 1'b1;
    repeat (3) tick();
    pad_in[0] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (gpi_out !== 4'b0110 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL short_glitch cycle %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("short glitch bit0: gpi=%h", gpi_out);
  endtask

  task automatic test_bypass();
    // Bit 0 is part-way through W_HIGH when bypass asserts: output snaps up.
    pad_in = 4'b0111;
    repeat (4) tick();
    checks++;
    if (gpi_out !== 4'b0110 || rise_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_pre gpi=%h rise=%h expected 6/0", gpi_out, rise_pulse);
    end
    bypass = 1'b1;
    tick();
    checks++;
    if (gpi_out !== 4'b0111 || rise_pulse !== 4'b0001 || fall_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_snap gpi=%h rise=%h fall=%h expected 7/1/0", gpi_out, rise_pulse, fall_pulse);
    end
    tick();
    checks++;
    if (rise_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL bypass_snap_clear rise=%h expected 0", rise_pulse);
    end
    pad_in = 4'b1111;
    for (int e = 0; e <= 3; e++) begin
      tick();
      checks++;
      if (gpi_out !== ((e >= 2) ? 4'b1111 : 4'b0111) || rise_pulse !== ((e == 2) ? 4'b1000 : 4'b0000)
          || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL bypass_rise edge %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    bypass = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (gpi_out !== 4'b1111 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL bypass_exit cycle %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("bypass: gpi=%h", gpi_out);
  endtask

  task automatic test_back_to_back();
    pad_in = 4'b0110;
    repeat (10) tick();
    checks++;
    if (gpi_out !== 4'b0110) begin
      errors++;
      $display("FAIL simul_prep gpi=%h expected 6", gpi_out);
    end
    pad_in = 4'b1111;
    for (int e = 0; e <= 7; e++) begin
      tick();
      checks++;
      if (gpi_out !== ((e >= 6) ? 4'b1111 : 4'b0110) || rise_pulse !== ((e == 6) ? 4'b1001 : 4'b0000)
          || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL simul_rise edge %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("simultaneous bits0,3: gpi=%h", gpi_out);
  endtask

  task automatic test_reset_mid_op();
    pad_in = 4'b1110;
    repeat (10) tick();
    checks++;
    if (gpi_out !== 4'b1110) begin
      errors++;
      $display("FAIL midop_prep gpi=%h expected e", gpi_out);
    end
    pad_in = 4'b1111;
    repeat (4) tick();
    #2;
    PRESET = 1'b1;
    #1;
    checks++;
    if (gpi_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
      errors++;
      $display("FAIL midop_async gpi=%h rise=%h fall=%h expected all 0", gpi_out, rise_pulse, fall_pulse);
    end
    pad_in = 4'b0000;
    repeat (2) tick();
    PRESET = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (gpi_out !== 4'b0000 || rise_pulse !== 4'b0000 || fall_pulse !== 4'b0000) begin
        errors++;
        $display("FAIL midop_after cycle %0d gpi=%h rise=%h fall=%h", e, gpi_out, rise_pulse, fall_pulse);
      end
    end
    $display("reset mid-op: gpi=%h", gpi_out);
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_short_glitch();
    test_bypass();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
